// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock-measurement scheduler.
package clk_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_WINDOW,
    ST_STOP,
    ST_WAIT,
    ST_OUT
  } state_t;

  localparam int RES_W = 8;
  localparam logic [RES_W-1:0] RES_ERR_VAL = 8'hFF;

  function automatic int ch_width(input int n_clk);
    return (n_clk > 1) ? $clog2(n_clk) : 1;
  endfunction

  // One down-counter serves settle, window and timeout, so size it for the largest.
  function automatic int cnt_width(input int win_log2, input int settle, input int tmo);
    int w;
    w = win_log2 + 1;
    if ($clog2(settle + 1) > w) w = $clog2(settle + 1);
    if ($clog2(tmo + 1) > w) w = $clog2(tmo + 1);
    return w;
  endfunction

endpackage

// File: rtl/clk_meas_sched_if.sv
// Datapath control/result and readout valid/ready bundle for the measurement scheduler.
interface clk_meas_sched_if #(
  parameter int N_CLK = 4
);
  import clk_meas_pkg::*;

  localparam int CH_W = ch_width(N_CLK);

  logic             dp_start;
  logic             dp_stop;
  logic             dp_valid;
  logic [RES_W-1:0] dp_mult;
  logic [RES_W-1:0] dp_frac;

  logic             res_valid;
  logic             res_ready;
  logic [CH_W-1:0]  res_ch;
  logic [RES_W-1:0] res_mult;
  logic [RES_W-1:0] res_frac;
  logic             res_err;

  modport master (
    output dp_start, dp_stop,
    input  dp_valid, dp_mult, dp_frac,
    output res_valid, res_ch, res_mult, res_frac, res_err,
    input  res_ready
  );

  modport slave (
    input  dp_start, dp_stop,
    output dp_valid, dp_mult, dp_frac,
    input  res_valid, res_ch, res_mult, res_frac, res_err,
    output res_ready
  );

endinterface

// File: rtl/clk_meas_rr_pick.sv
// Round-robin channel picker: first set mask bit starting at cur (incl=1) or after cur (incl=0).
module clk_meas_rr_pick #(
  parameter int N_CLK = 4,
  parameter int CH_W  = 2
) (
  input  logic [N_CLK-1:0] mask,
  input  logic [CH_W-1:0]  cur,
  input  logic             incl,
  output logic [CH_W-1:0]  pick,
  output logic             found
);

  int             idx;
  logic [CH_W-1:0] idx_c;

  // Exclusive search still visits cur last, so a lone set bit re-selects itself.
  always_comb begin
    pick  = cur;
    found = 1'b0;
    idx   = 0;
    idx_c = '0;
    for (int k = 0; k < N_CLK; k++) begin
      idx   = (int'(cur) + (incl ? 0 : 1) + k) % N_CLK;
      idx_c = CH_W'(idx);
      if (!found && mask[idx_c]) begin
        found = 1'b1;
        pick  = idx_c;
      end
    end
  end

endmodule

// File: rtl/clk_meas_sched.sv
// Round-robin frequency-measurement sequencer: select, settle, timed window, collect, report.
module clk_meas_sched
  import clk_meas_pkg::*;
#(
  parameter  int N_CLK    = 4,
  parameter  int WIN_LOG2 = 8,
  parameter  int SETTLE   = 4,
  parameter  int TMO      = 64,
  localparam int CH_W     = ch_width(N_CLK)
) (
  input  logic             ref_clk,
  input  logic             w_rst,
  input  logic             en,
  input  logic [N_CLK-1:0] ch_mask,
  output logic [CH_W-1:0]  sel,
  output logic             busy,
  clk_meas_sched_if.master bus
);

  localparam int CNT_W = cnt_width(WIN_LOG2, SETTLE, TMO);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] WIN_LD    = CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TMO - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             sel_ld;
  logic             cap_ok;
  logic             cap_tmo;
  logic [CH_W-1:0]  pick;
  logic             found;

  logic [CH_W-1:0]  sel_r;
  logic [CH_W-1:0]  res_ch_r;
  logic [RES_W-1:0] res_mult_r;
  logic [RES_W-1:0] res_frac_r;
  logic             res_err_r;

  // A timed-out measurement reports the all-ones marker instead of datapath data.
  function automatic logic [RES_W-1:0] res_word(input logic err, input logic [RES_W-1:0] v);
    return err ? RES_ERR_VAL : v;
  endfunction

  clk_meas_rr_pick #(
    .N_CLK (N_CLK),
    .CH_W  (CH_W)
  ) u_pick (
    .mask  (ch_mask),
    .cur   (sel_r),
    .incl  (state == ST_IDLE),
    .pick  (pick),
    .found (found)
  );

  always_ff @(posedge ref_clk) begin
    if (w_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_ld   = 1'b0;
    cap_ok   = 1'b0;
    cap_tmo  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && found) begin
          sel_ld   = 1'b1;
          cnt_nx   = SETTLE_LD;
          state_nx = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (cnt == '0) state_nx = ST_START;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      ST_START: begin
        cnt_nx   = WIN_LD;
        state_nx = ST_WINDOW;
      end
      ST_WINDOW: begin
        if (cnt == '0) state_nx = ST_STOP;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      ST_STOP: begin
        cnt_nx   = TMO_LD;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the last allowed cycle still beats the timeout.
        if (bus.dp_valid) begin
          cap_ok   = 1'b1;
          state_nx = ST_OUT;
        end else if (cnt == '0) begin
          cap_tmo  = 1'b1;
          state_nx = ST_OUT;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (bus.res_ready) begin
          if (en && found) begin
            sel_ld   = 1'b1;
            cnt_nx   = SETTLE_LD;
            state_nx = ST_SELECT;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (w_rst) begin
      sel_r      <= '0;
      res_ch_r   <= '0;
      res_mult_r <= '0;
      res_frac_r <= '0;
      res_err_r  <= 1'b0;
    end else begin
      if (sel_ld) sel_r <= pick;
      if (cap_ok || cap_tmo) begin
        res_ch_r   <= sel_r;
        res_mult_r <= res_word(cap_tmo, bus.dp_mult);
        res_frac_r <= res_word(cap_tmo, bus.dp_frac);
        res_err_r  <= cap_tmo;
      end
    end
  end

  assign sel           = sel_r;
  assign busy          = (state != ST_IDLE);
  assign bus.dp_start  = (state == ST_START);
  assign bus.dp_stop   = (state == ST_STOP);
  assign bus.res_valid = (state == ST_OUT);
  assign bus.res_ch    = res_ch_r;
  assign bus.res_mult  = res_mult_r;
  assign bus.res_frac  = res_frac_r;
  assign bus.res_err   = res_err_r;

endmodule

// File: tb/tb_clk_meas_sched.sv
// Bench for clk_meas_sched: behavioural datapath model, result scoreboard, start-spacing checks.
module tb_clk_meas_sched;
  import clk_meas_pkg::*;

  localparam int N_CLK    = 4;
  localparam int WIN_LOG2 = 8;
  localparam int SETTLE   = 4;
  localparam int TMO      = 64;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int MEAS_BUD = 400;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] mult;
    logic [7:0] frac;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic [3:0]      mask;
    logic [7:0]      dly;   // dp_valid delay after dp_stop, 0 = never
    logic            err;   // expected res_err for every result of the row
    logic [2:0]      n;
    logic [3:0][1:0] chs;   // expected channel order
  } vec_t;

  logic             ref_clk = 1'b0;
  logic             w_rst   = 1'b1;
  logic             en      = 1'b0;
  logic [N_CLK-1:0] ch_mask = '0;
  logic [1:0]       sel;
  logic             busy;

  clk_meas_sched_if #(.N_CLK(N_CLK)) bus ();

  clk_meas_sched #(
    .N_CLK    (N_CLK),
    .WIN_LOG2 (WIN_LOG2),
    .SETTLE   (SETTLE),
    .TMO      (TMO)
  ) dut (
    .ref_clk (ref_clk),
    .w_rst   (w_rst),
    .en      (en),
    .ch_mask (ch_mask),
    .sel     (sel),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 ref_clk = ~ref_clk;

  exp_t       sb_q[$];
  logic [1:0] ch_q[$];
  int         compared = 0;
  int         mismatched = 0;
  int         hs = 0;
  int         starts = 0;
  int         cyc = 0;
  int         prev_cyc = 0;
  bit         have_prev = 1'b0;
  int         cur_dly = 2;
  logic       cur_exp_err = 1'b0;
  logic [1:0] cur_ch = '0;

  always @(posedge ref_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] m, input int d, input logic e, input int n,
                              input int c0, input int c1, input int c2, input int c3);
    vec_t v;
    v.mask   = m;
    v.dly    = 8'(d);
    v.err    = e;
    v.n      = 3'(n);
    v.chs[0] = 2'(c0);
    v.chs[1] = 2'(c1);
    v.chs[2] = 2'(c2);
    v.chs[3] = 2'(c3);
    return v;
  endfunction

  // Start monitor and result scoreboard, sampled mid-cycle.
  always @(negedge ref_clk) begin : mon
    exp_t e;
    exp_t got;
    int   gap;
    if (bus.dp_start) begin
      starts++;
      if (ch_q.size() == 0) begin
        check("start_unexpected", 64'(starts), 64'(0));
      end else begin
        cur_ch = ch_q.pop_front();
        check("start_sel", 64'(sel), 64'(cur_ch));
      end
      gap = SETTLE + 1 + WIN + 1 + (cur_exp_err ? TMO : cur_dly) + 1;
      if (have_prev) check("start_gap", 64'(cyc - prev_cyc), 64'(gap));
      have_prev = 1'b1;
      prev_cyc  = cyc;
    end
    if (bus.res_valid && bus.res_ready) begin
      hs++;
      got = {bus.res_ch, bus.res_mult, bus.res_frac, bus.res_err};
      if (sb_q.size() == 0) begin
        check("result_unexpected", 64'(got), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check("result", 64'(got), 64'(e));
      end
    end
  end

  // Behavioural clk_compare datapath: answers dp_stop after cur_dly cycles.
  initial begin : dp_model
    int         d;
    logic       e;
    logic [1:0] ch;
    logic [7:0] m;
    logic [7:0] f;
    bus.dp_valid = 1'b0;
    bus.dp_mult  = '0;
    bus.dp_frac  = '0;
    forever begin
      @(posedge ref_clk);
      #1;
      if (bus.dp_stop && !w_rst) begin
        d  = cur_dly;
        e  = cur_exp_err;
        ch = cur_ch;
        if (e) sb_q.push_back({ch, RES_ERR_VAL, RES_ERR_VAL, 1'b1});
        if (d != 0) begin
          repeat (d) @(posedge ref_clk);
          #1;
          m = 8'($urandom);
          f = 8'($urandom);
          bus.dp_valid = 1'b1;
          bus.dp_mult  = m;
          bus.dp_frac  = f;
          if (!e) sb_q.push_back({ch, m, f, 1'b0});
          @(posedge ref_clk);
          #1;
          bus.dp_valid = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge ref_clk);
    #1;
    w_rst = 1'b1;
    en    = 1'b0;
    @(posedge ref_clk);
    #1;
    w_rst = 1'b0;
    ch_q.delete();
    sb_q.delete();
    have_prev = 1'b0;
    @(negedge ref_clk);
    check("reset_state",
          64'({sel, bus.dp_start, bus.dp_stop, bus.res_valid, bus.res_ch,
               bus.res_mult, bus.res_frac, bus.res_err, busy}), 64'(0));
  endtask

  task automatic wait_hs(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (hs < target && k < budget) begin
      @(negedge ref_clk);
      #1;
      k++;
    end
    check(nm, 64'(hs >= target), 64'(1));
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge ref_clk);
      #1;
      k++;
    end
    check(nm, 64'(busy), 64'(0));
  endtask

  // Runs n measurements, dropping en during the last so the FSM parks in IDLE.
  task automatic run_row(input vec_t v);
    int base;
    int n;
    n           = int'(v.n);
    ch_mask     = v.mask;
    cur_dly     = int'(v.dly);
    cur_exp_err = v.err;
    for (int i = 0; i < n; i++) ch_q.push_back(v.chs[i]);
    base = hs;
    @(posedge ref_clk);
    #1;
    en = 1'b1;
    if (n > 1) wait_hs(base + n - 1, MEAS_BUD * n, "row_results_pre");
    @(posedge ref_clk);
    #1;
    en = 1'b0;
    wait_hs(base + n, MEAS_BUD * 2, "row_results");
    wait_idle("row_idle");
    check("row_sb_empty", 64'(sb_q.size()), 64'(0));
    check("row_ch_empty", 64'(ch_q.size()), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : main
    vec_t       vecs[6];
    int         base;
    int         s0;
    int         s1;
    int         k;
    bit         stable;
    logic [18:0] snap;

    bus.res_ready = 1'b1;
    vecs[0] = mk(4'b1011, 2,  1'b0, 4, 0, 1, 3, 0);
    vecs[1] = mk(4'b0100, 2,  1'b0, 3, 2, 2, 2, 0);
    vecs[2] = mk(4'b1000, 0,  1'b1, 1, 3, 0, 0, 0);
    vecs[3] = mk(4'b0110, 64, 1'b0, 2, 1, 2, 0, 0);
    vecs[4] = mk(4'b0001, 65, 1'b1, 2, 0, 0, 0, 0);
    vecs[5] = mk(4'b1100, 1,  1'b0, 3, 2, 3, 2, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_row(vecs[i]);
    end

    // Back-pressure: result held, no new start while res_ready is low.
    do_reset();
    ch_mask       = 4'b0001;
    cur_dly       = 2;
    cur_exp_err   = 1'b0;
    bus.res_ready = 1'b0;
    ch_q.push_back(2'd0);
    base = hs;
    @(posedge ref_clk);
    #1;
    en = 1'b1;
    k = 0;
    while (!bus.res_valid && k < MEAS_BUD) begin
      @(negedge ref_clk);
      #1;
      k++;
    end
    check("bp_valid_seen", 64'(bus.res_valid), 64'(1));
    snap   = {bus.res_ch, bus.res_mult, bus.res_frac, bus.res_err};
    s0     = starts;
    stable = 1'b1;
    repeat (500) begin
      @(negedge ref_clk);
      #1;
      if (!bus.res_valid || {bus.res_ch, bus.res_mult, bus.res_frac, bus.res_err} !== snap)
        stable = 1'b0;
    end
    check("bp_hold", 64'(stable), 64'(1));
    check("bp_no_start", 64'(starts), 64'(s0));
    @(posedge ref_clk);
    #1;
    en            = 1'b0;
    bus.res_ready = 1'b1;
    wait_hs(base + 1, 10, "bp_release");
    @(negedge ref_clk);
    check("bp_valid_drop", 64'(bus.res_valid), 64'(0));
    wait_idle("bp_idle");

    // en dropped mid-window: measurement finishes, then idle with no new start.
    do_reset();
    ch_mask     = 4'b1111;
    cur_dly     = 2;
    cur_exp_err = 1'b0;
    ch_q.push_back(2'd0);
    base = hs;
    s0   = starts;
    @(posedge ref_clk);
    #1;
    en = 1'b1;
    k = 0;
    while (starts == s0 && k < 50) begin
      @(negedge ref_clk);
      #1;
      k++;
    end
    repeat (20) @(posedge ref_clk);
    #1;
    en = 1'b0;
    wait_hs(base + 1, MEAS_BUD, "endrop_result");
    wait_idle("endrop_idle");
    s1 = starts;
    repeat (300) @(negedge ref_clk);
    check("endrop_one_start", 64'(s1), 64'(s0 + 1));
    check("endrop_no_restart", 64'(starts), 64'(s1));
    check("endrop_busy", 64'(busy), 64'(0));

    // Reset while waiting for dp_valid, then a clean re-run from channel 0.
    do_reset();
    ch_mask     = 4'b0011;
    cur_dly     = 0;
    cur_exp_err = 1'b1;
    ch_q.push_back(2'd0);
    @(posedge ref_clk);
    #1;
    en = 1'b1;
    k = 0;
    while (!bus.dp_stop && k < MEAS_BUD) begin
      @(negedge ref_clk);
      k++;
    end
    repeat (5) @(negedge ref_clk);
    check("rst_wait_busy", 64'(busy), 64'(1));
    do_reset();
    run_row(mk(4'b0011, 2, 1'b0, 2, 0, 1, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
